// File: rtl/fp_div_unit.sv
// fp_div_unit: iterative binary32 FDIV.S (radix-2 restoring, RNE, flush-to-zero) feeding the FP register file write port
module fp_div_unit #(
  parameter int ADDR_W = 5,
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              kill,
  input  logic [ADDR_W-1:0] rd_addr_in,
  input  logic [31:0]       frs1_data,
  input  logic [31:0]       frs2_data,
  output logic              busy,
  output logic              frd_en,
  output logic [ADDR_W-1:0] frd_addr,
  output logic [31:0]       frd_data,
  output logic [4:0]        fflags
);
  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;
  state_t state;
  logic [4:0] cnt;
  logic [24:0] rem;
  logic [23:0] mb;
  logic [25:0] q;
  logic signed [9:0] exp_r;
  logic sign;
  logic [31:0] res;
  logic [4:0] flg;
  logic [ADDR_W-1:0] rd;
  logic [7:0] e1, e2;
  logic [22:0] f1, f2;
  logic z1, z2, inf1, inf2, nan1, nan2, nan_any, invalid, special, s;
  logic [31:0] spec_res;
  logic [4:0] spec_flg;
  assign e1 = frs1_data[30:23];
  assign e2 = frs2_data[30:23];
  assign f1 = frs1_data[22:0];
  assign f2 = frs2_data[22:0];
  assign s = frs1_data[31] ^ frs2_data[31];
  assign z1 = e1 == 8'd0;
  assign z2 = e2 == 8'd0;
  assign inf1 = &e1 & ~|f1;
  assign inf2 = &e2 & ~|f2;
  assign nan1 = &e1 & |f1;
  assign nan2 = &e2 & |f2;
  assign nan_any = nan1 | nan2;
  assign invalid = (z1 & z2) | (inf1 & inf2);
  assign special = nan_any | z1 | z2 | inf1 | inf2;
  assign spec_res = (nan_any | invalid) ? CANON_NAN :
                    (inf1 | z2) ? {s, 8'hFF, 23'd0} : {s, 31'd0};
  // quiet NaNs pass through silently; only signalling NaNs or 0/0, inf/inf raise NV
  assign spec_flg = {nan_any ? ((nan1 & ~f1[22]) | (nan2 & ~f2[22])) : invalid,
                     ~nan_any & z2 & ~z1 & ~inf1, 3'd0};
  logic ge;
  logic [24:0] rsub;
  assign ge = rem >= {1'b0, mb};
  assign rsub = ge ? rem - {1'b0, mb} : rem;
  logic sh, g, st, inc, of, uf;
  logic [23:0] sig;
  logic [24:0] sum;
  logic [22:0] frac;
  logic signed [9:0] ex;
  logic [31:0] rnd_res;
  assign sh = ~q[25];
  assign sig = sh ? q[24:1] : q[25:2];
  assign g = sh ? q[0] : q[1];
  assign st = (~sh & q[0]) | (|rem);
  assign inc = g & (st | sig[0]);
  assign sum = {1'b0, sig} + {24'd0, inc};
  assign frac = sum[24] ? sum[23:1] : sum[22:0];
  assign ex = exp_r - {9'd0, sh} + {9'd0, sum[24]};
  assign of = ex > 10'sd254;
  assign uf = ex < 10'sd1;
  assign rnd_res = of ? {sign, 8'hFF, 23'd0} : uf ? {sign, 31'd0} : {sign, ex[7:0], frac};
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      rem <= '0;
      mb <= '0;
      q <= '0;
      exp_r <= '0;
      sign <= 1'b0;
      res <= '0;
      flg <= '0;
      rd <= '0;
      frd_en <= 1'b0;
      frd_addr <= '0;
      frd_data <= '0;
      fflags <= '0;
    end else begin
      frd_en <= 1'b0;
      fflags <= '0;
      if (kill) begin
        state <= IDLE;
        cnt <= '0;
      end else begin
        case (state)
          IDLE: if (start) begin
            rd <= rd_addr_in;
            sign <= s;
            res <= spec_res;
            flg <= spec_flg;
            rem <= {2'b01, f1};
            mb <= {1'b1, f2};
            q <= '0;
            exp_r <= $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;
            cnt <= 5'd25;
            state <= special ? DONE : DIV;
          end
          DIV: begin
            rem <= {rsub[23:0], 1'b0};
            q <= {q[24:0], ge};
            cnt <= cnt == 5'd0 ? 5'd0 : cnt - 5'd1;
            state <= cnt == 5'd0 ? ROUND : DIV;
          end
          ROUND: begin
            res <= rnd_res;
            flg <= {2'b00, of, uf, of | uf | g | st};
            state <= DONE;
          end
          default: begin
            frd_en <= 1'b1;
            frd_addr <= rd;
            frd_data <= res;
            fflags <= flg;
            state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fp_div_unit.sv
// tb_fp_div_unit: directed FDIV.S vectors with hand-computed results, latency, kill and reset checks
module tb_fp_div_unit;
  logic clk = 0, rst = 0, start = 0, kill = 0;
  logic [4:0] rd_addr_in = 0;
  logic [31:0] frs1_data = 0, frs2_data = 0;
  logic busy, frd_en;
  logic [4:0] frd_addr, fflags;
  logic [31:0] frd_data;
  int vectors = 0, errs = 0, pulses = 0;

  fp_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .rd_addr_in(rd_addr_in),
    .frs1_data(frs1_data), .frs2_data(frs2_data), .busy(busy), .frd_en(frd_en),
    .frd_addr(frd_addr), .frd_data(frd_data), .fflags(fflags)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (frd_en) pulses++;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int g = 0;
    @(negedge clk);
    while (busy && g < 100) begin @(negedge clk); g++; end
    start = 1; frs1_data = a; frs2_data = b; rd_addr_in = rd;
    @(posedge clk);
    #1 start = 0; frs1_data = $urandom; frs2_data = $urandom; rd_addr_in = 5'($urandom);
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] ed, input logic [4:0] ef, input int lat);
    int k = 0;
    issue(a, b, rd);
    while (!frd_en && k < 100) begin @(posedge clk); #1; k++; end
    chk({tag, "_lat"}, k, lat);
    chk({tag, "_addr"}, frd_addr, rd);
    chk({tag, "_data"}, frd_data, ed);
    chk({tag, "_flags"}, fflags, ef);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, frd_en, 0);
    chk({tag, "_flags_clr"}, fflags, 0);
  endtask

  initial begin
    int p0, n, k1, k2;
    logic [31:0] d1, d2;
    logic [4:0] a1, a2;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_en", frd_en, 0);
    chk("rst_addr", frd_addr, 0);
    chk("rst_data", frd_data, 0);
    chk("rst_flags", fflags, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    do_op("div6_2", 32'h40C00000, 32'h40000000, 5'd5, 32'h40400000, 5'b00000, 28);
    do_op("div1_3", 32'h3F800000, 32'h40400000, 5'd7, 32'h3EAAAAAB, 5'b00001, 28);
    do_op("div2_3", 32'h40000000, 32'h40400000, 5'd8, 32'h3F2AAAAB, 5'b00001, 28);
    do_op("neg6_2", 32'hC0C00000, 32'h40000000, 5'd9, 32'hC0400000, 5'b00000, 28);
    do_op("one_one", 32'h3F800000, 32'h3F800000, 5'd10, 32'h3F800000, 5'b00000, 28);
    do_op("x_zero", 32'h3F800000, 32'h00000000, 5'd11, 32'h7F800000, 5'b01000, 1);
    do_op("zero_zero", 32'h00000000, 32'h00000000, 5'd12, 32'h7FC00000, 5'b10000, 1);
    do_op("qnan", 32'h7FC00000, 32'h3F800000, 5'd13, 32'h7FC00000, 5'b00000, 1);
    do_op("snan", 32'h7F800001, 32'h3F800000, 5'd14, 32'h7FC00000, 5'b10000, 1);
    do_op("inf_inf", 32'h7F800000, 32'h7F800000, 5'd15, 32'h7FC00000, 5'b10000, 1);
    do_op("ninf_x", 32'hFF800000, 32'h40000000, 5'd16, 32'hFF800000, 5'b00000, 1);
    do_op("x_inf", 32'hC0400000, 32'h7F800000, 5'd17, 32'h80000000, 5'b00000, 1);
    do_op("sub_x", 32'h00000001, 32'h3F800000, 5'd18, 32'h00000000, 5'b00000, 1);
    do_op("unf", 32'h00800000, 32'h4B000000, 5'd20, 32'h00000000, 5'b00011, 28);
    do_op("ovf", 32'h7F7FFFFF, 32'h3E800000, 5'd19, 32'h7F800000, 5'b00101, 28);
    chk("hold_data", frd_data, 32'h7F800000);
    chk("hold_addr", frd_addr, 5'd19);
    // abort mid-DIV, then restart the very next cycle
    issue(32'h40C00000, 32'h40000000, 5'd3);
    p0 = pulses;
    repeat (9) @(posedge clk);
    @(negedge clk) kill = 1;
    @(posedge clk);
    #1 kill = 0;
    chk("kill_busy", busy, 0);
    do_op("after_kill", 32'h40C00000, 32'h40000000, 5'd4, 32'h40400000, 5'b00000, 28);
    chk("kill_pulses", pulses, p0 + 1);
    // kill in the DONE cycle suppresses the write
    issue(32'h3F800000, 32'h00000000, 5'd6);
    p0 = pulses;
    kill = 1;
    @(posedge clk);
    #1 kill = 0;
    chk("kill_done_en", frd_en, 0);
    chk("kill_done_busy", busy, 0);
    repeat (3) @(posedge clk);
    chk("kill_done_pulses", pulses, p0);
    // asynchronous reset mid-DIV
    issue(32'h40C00000, 32'h40000000, 5'd2);
    p0 = pulses;
    repeat (5) @(posedge clk);
    #2 rst = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_en", frd_en, 0);
    chk("arst_addr", frd_addr, 0);
    chk("arst_data", frd_data, 0);
    chk("arst_flags", fflags, 0);
    @(negedge clk) rst = 1;
    repeat (35) @(posedge clk);
    chk("arst_pulses", pulses, p0);
    // start held high: second op accepted on the first idle cycle after DONE
    @(negedge clk);
    start = 1; frs1_data = 32'h40C00000; frs2_data = 32'h40000000; rd_addr_in = 5'd21;
    @(posedge clk);
    #1 frs1_data = 32'h3F800000; frs2_data = 32'h40400000; rd_addr_in = 5'd22;
    n = 0; k1 = 0; k2 = 0; d1 = 0; d2 = 0; a1 = 0; a2 = 0;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk); #1;
      if (frd_en) begin
        n++;
        if (n == 1) begin k1 = k; d1 = frd_data; a1 = frd_addr; end
        else begin k2 = k; d2 = frd_data; a2 = frd_addr; end
      end
    end
    start = 0;
    chk("b2b_count", n, 2);
    chk("b2b_lat1", k1, 28);
    chk("b2b_data1", d1, 32'h40400000);
    chk("b2b_addr1", a1, 5'd21);
    chk("b2b_lat2", k2, 57);
    chk("b2b_data2", d2, 32'h3EAAAAAB);
    chk("b2b_addr2", a2, 5'd22);
    repeat (40) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
